// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller driving a BSCANE2-style user-scan interface.
// Holds IR, IDCODE and BYPASS registers and returns the selected TDO on the TCK falling edge.
`timescale 1ns/1ps
module jtag_tap_ctrl #(
  parameter int unsigned       IR_LEN    = 6,
  parameter logic [IR_LEN-1:0] USER_IR   = 6'h02,
  parameter logic [IR_LEN-1:0] IDCODE_IR = 6'h09,
  parameter logic [31:0]       IDCODE    = 32'h13631093
) (
  input  logic TCK,
  input  logic TRST_N,
  input  logic TMS,
  input  logic TDI,
  output logic TDO,
  output logic TDO_EN,
  input  logic USER_TDO,
  output logic CAPTURE,
  output logic SHIFT,
  output logic UPDATE,
  output logic RESET,
  output logic RUNTEST,
  output logic SEL,
  output logic USER_TDI
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e        state, state_nxt;
  logic [IR_LEN-1:0] ir, ir_shift;
  logic [31:0]       idcode_shift;
  logic              bypass;
  logic              dr_idcode, dr_user, dr_tdo;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) state <= TLR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    CAPTURE   = 1'b0;
    SHIFT     = 1'b0;
    UPDATE    = 1'b0;
    RESET     = 1'b0;
    RUNTEST   = 1'b0;
    case (state)
      TLR:      begin state_nxt = TMS ? TLR    : RTI;      RESET   = 1'b1; end
      RTI:      begin state_nxt = TMS ? SEL_DR : RTI;      RUNTEST = 1'b1; end
      SEL_DR:         state_nxt = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   begin state_nxt = TMS ? EX1_DR : SH_DR;    CAPTURE = 1'b1; end
      SH_DR:    begin state_nxt = TMS ? EX1_DR : SH_DR;    SHIFT   = 1'b1; end
      EX1_DR:         state_nxt = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR:       state_nxt = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:         state_nxt = TMS ? UPD_DR : SH_DR;
      UPD_DR:   begin state_nxt = TMS ? SEL_DR : RTI;      UPDATE  = 1'b1; end
      SEL_IR:         state_nxt = TMS ? TLR    : CAP_IR;
      CAP_IR:         state_nxt = TMS ? EX1_IR : SH_IR;
      SH_IR:          state_nxt = TMS ? EX1_IR : SH_IR;
      EX1_IR:         state_nxt = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR:       state_nxt = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:         state_nxt = TMS ? UPD_IR : SH_IR;
      UPD_IR:         state_nxt = TMS ? SEL_DR : RTI;
      default:        state_nxt = TLR;
    endcase
  end

  // IR is forced to IDCODE on every edge spent in Test-Logic-Reset
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir       <= IDCODE_IR;
      ir_shift <= '0;
    end else begin
      case (state)
        TLR:     ir       <= IDCODE_IR;
        CAP_IR:  ir_shift <= {{(IR_LEN-2){1'b0}}, 2'b01};
        SH_IR:   ir_shift <= {TDI, ir_shift[IR_LEN-1:1]};
        UPD_IR:  ir       <= ir_shift;
        default: ;
      endcase
    end
  end

  assign dr_idcode = (ir == IDCODE_IR);
  assign dr_user   = (ir == USER_IR);
  assign SEL       = dr_user;
  assign USER_TDI  = TDI;

  // USER_IR leaves both local data registers untouched
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      idcode_shift <= '0;
      bypass       <= 1'b0;
    end else if (dr_idcode) begin
      if (state == CAP_DR)     idcode_shift <= IDCODE;
      else if (state == SH_DR) idcode_shift <= {TDI, idcode_shift[31:1]};
    end else if (!dr_user) begin
      if (state == CAP_DR)     bypass <= 1'b0;
      else if (state == SH_DR) bypass <= TDI;
    end
  end

  always_comb begin
    dr_tdo = bypass;
    if (dr_idcode)    dr_tdo = idcode_shift[0];
    else if (dr_user) dr_tdo = USER_TDO;
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO_EN <= (state == SH_IR) || (state == SH_DR);
      if (state == SH_IR)      TDO <= ir_shift[0];
      else if (state == SH_DR) TDO <= dr_tdo;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed scans plus random TMS/TDI traffic
// checked against a table-driven TAP model with queue-based shift registers.
`timescale 1ns/1ps
module tb_jtag_tap_ctrl;

  localparam logic [5:0]  USER_IR   = 6'h02;
  localparam logic [5:0]  IDCODE_IR = 6'h09;
  localparam logic [31:0] IDCODE    = 32'h13631093;

  logic TCK = 1'b0, TRST_N = 1'b1, TMS = 1'b1, TDI = 1'b0, USER_TDO = 1'b0;
  logic TDO, TDO_EN, CAPTURE, SHIFT, UPDATE, RESET, RUNTEST, SEL, USER_TDI;

  int checks = 0, failures = 0;
  int cap_cnt = 0, sh_cnt = 0, upd_cnt = 0;
  logic last_tdo;

  // reference model
  string      m_state;
  string      nx0[string], nx1[string];
  logic [5:0] m_ir;
  bit         irq[$], drq[$];
  logic       m_tdo, m_tdo_en;

  jtag_tap_ctrl #(.IR_LEN(6), .USER_IR(USER_IR), .IDCODE_IR(IDCODE_IR), .IDCODE(IDCODE)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .USER_TDO(USER_TDO), .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE),
    .RESET(RESET), .RUNTEST(RUNTEST), .SEL(SEL), .USER_TDI(USER_TDI)
  );

  always #5 TCK = ~TCK;

  function automatic void tr(input string s, input string on0, input string on1);
    nx0[s] = on0;
    nx1[s] = on1;
  endfunction

  function automatic void init_tables();
    tr("TLR", "RTI", "TLR");         tr("RTI", "RTI", "SelDR");
    tr("SelDR", "CapDR", "SelIR");   tr("CapDR", "ShDR", "Ex1DR");
    tr("ShDR", "ShDR", "Ex1DR");     tr("Ex1DR", "PauseDR", "UpdDR");
    tr("PauseDR", "PauseDR", "Ex2DR"); tr("Ex2DR", "ShDR", "UpdDR");
    tr("UpdDR", "RTI", "SelDR");     tr("SelIR", "CapIR", "TLR");
    tr("CapIR", "ShIR", "Ex1IR");    tr("ShIR", "ShIR", "Ex1IR");
    tr("Ex1IR", "PauseIR", "UpdIR"); tr("PauseIR", "PauseIR", "Ex2IR");
    tr("Ex2IR", "ShIR", "UpdIR");    tr("UpdIR", "RTI", "SelDR");
  endfunction

  function automatic void model_reset();
    m_state  = "TLR";
    m_ir     = IDCODE_IR;
    m_tdo    = 1'b0;
    m_tdo_en = 1'b0;
  endfunction

  function automatic void model_rise(input logic tms, input logic tdi);
    if (m_state == "TLR") begin
      m_ir = IDCODE_IR;
    end else if (m_state == "CapIR") begin
      irq.delete();
      irq.push_back(1'b1);
      for (int i = 1; i < 6; i++) irq.push_back(1'b0);
    end else if (m_state == "ShIR") begin
      void'(irq.pop_front());
      irq.push_back(tdi);
    end else if (m_state == "UpdIR") begin
      for (int i = 0; i < 6; i++) m_ir[i] = irq[i];
    end else if (m_state == "CapDR") begin
      if (m_ir == IDCODE_IR) begin
        drq.delete();
        for (int i = 0; i < 32; i++) drq.push_back(IDCODE[i]);
      end else if (m_ir != USER_IR) begin
        drq.delete();
        drq.push_back(1'b0);
      end
    end else if (m_state == "ShDR") begin
      if (m_ir != USER_IR) begin
        void'(drq.pop_front());
        drq.push_back(tdi);
      end
    end
    m_state = tms ? nx1[m_state] : nx0[m_state];
  endfunction

  function automatic void model_fall(input logic utdo);
    if (m_state == "ShIR")      m_tdo = irq[0];
    else if (m_state == "ShDR") m_tdo = (m_ir == USER_IR) ? utdo : drq[0];
    m_tdo_en = (m_state == "ShIR") || (m_state == "ShDR");
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk1("capture", CAPTURE, m_state == "CapDR");
    chk1("shift",   SHIFT,   m_state == "ShDR");
    chk1("update",  UPDATE,  m_state == "UpdDR");
    chk1("reset",   RESET,   m_state == "TLR");
    chk1("runtest", RUNTEST, m_state == "RTI");
    chk1("sel",     SEL,     m_ir == USER_IR);
  endtask

  // Entered and left just after a falling edge; one full TCK per call.
  task automatic step(input logic tms, input logic tdi, input logic utdo);
    TMS = tms; TDI = tdi; USER_TDO = utdo;
    @(posedge TCK);
    model_rise(tms, tdi);
    #1;
    chk_status();
    chk1("user_tdi", USER_TDI, tdi);
    if (CAPTURE) cap_cnt++;
    if (SHIFT)   sh_cnt++;
    if (UPDATE)  upd_cnt++;
    @(negedge TCK);
    model_fall(utdo);
    #1;
    chk1("tdo",    TDO,    m_tdo);
    chk1("tdo_en", TDO_EN, m_tdo_en);
    last_tdo = TDO;
  endtask

  task automatic to_rti();
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // From RTI: load IR, return to RTI; seq holds TDO seen in Shift-IR, first bit in MSB
  task automatic shift_ir(input logic [5:0] v, output logic [5:0] seq);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    seq = {5'b0, last_tdo};
    for (int i = 0; i < 6; i++) begin
      step(i == 5, v[i], 1'b0);
      if (i < 5) seq = {seq[4:0], last_tdo};
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] word;
    logic [3:0]  tail;
    logic [4:0]  bseq;
    logic [5:0]  iseq;
    logic [63:0] rom, rd;
    logic [5:0]  pick;

    init_tables();

    // reset held for 3 TCK
    TRST_N = 1'b0;
    model_reset();
    #1;
    chk_status();
    chk1("tdo_en_rst", TDO_EN, 1'b0);
    repeat (3) @(posedge TCK);
    @(negedge TCK);
    #1;
    chk_status();
    chk1("reset_held", RESET, 1'b1);
    TRST_N = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk1("runtest_after_reset", RUNTEST, 1'b1);
    chk1("sel_after_reset", SEL, 1'b0);

    // IDCODE readout, then zeros
    upd_cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    word[0] = last_tdo;
    for (int k = 1; k < 32; k++) begin
      step(1'b0, 1'b0, 1'b0);
      word[k] = last_tdo;
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0);
      tail[k] = last_tdo;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chkw("idcode_word", 64'(word), 64'(IDCODE));
    chkw("idcode_tail", 64'(tail), 64'd0);
    chkw("idcode_update_count", 64'(upd_cnt), 64'd1);

    // five TMS=1 from Shift-DR reach TLR
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    upd_cnt = 0;
    repeat (5) step(1'b1, 1'b0, 1'b0);
    chk1("tlr_after_5", RESET, 1'b1);
    chkw("tlr_path_updates", 64'(upd_cnt), 64'd1);
    step(1'b0, 1'b0, 1'b0);

    // BYPASS: one-bit delay with leading captured 0
    shift_ir(6'h3F, iseq);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    bseq = {4'b0, last_tdo};
    step(1'b0, 1'b1, 1'b0); bseq = {bseq[3:0], last_tdo};
    step(1'b0, 1'b0, 1'b0); bseq = {bseq[3:0], last_tdo};
    step(1'b0, 1'b1, 1'b0); bseq = {bseq[3:0], last_tdo};
    step(1'b0, 1'b1, 1'b0); bseq = {bseq[3:0], last_tdo};
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chkw("bypass_seq", 64'(bseq), 64'(5'b01011));

    // USER1 IR scan, then a 64-bit user DR read
    shift_ir(USER_IR, iseq);
    chkw("ir_capture_seq", 64'(iseq), 64'(6'b100000));
    chk1("sel_user", SEL, 1'b1);
    rom = {$urandom, $urandom};
    cap_cnt = 0; sh_cnt = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, rom[0]);
    rd[0] = last_tdo;
    for (int k = 1; k < 64; k++) begin
      step(1'b0, 1'b0, rom[k]);
      rd[k] = last_tdo;
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chkw("user_capture_cycles", 64'(cap_cnt), 64'd1);
    chkw("user_shift_cycles", 64'(sh_cnt), 64'd64);
    chkw("user_readout", rd, rom);

    // TRST_N asserted during the 10th user bit
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, k[0]);
    chk1("shift_before_trst", SHIFT, 1'b1);
    TRST_N = 1'b0;
    model_reset();
    #1;
    chk1("trst_shift_drop", SHIFT, 1'b0);
    chk1("trst_reset", RESET, 1'b1);
    chk1("trst_sel", SEL, 1'b0);
    chk_status();
    @(posedge TCK);
    @(negedge TCK);
    #1;
    TRST_N = 1'b1;
    upd_cnt = 0;
    repeat (4) step(1'b0, 1'b0, 1'b1);
    chkw("trst_no_update", 64'(upd_cnt), 64'd0);
    chk1("trst_sel_after", SEL, 1'b0);

    // Exit1-IR straight to Update-IR loads the captured 000001 pattern
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chkw("noshift_ir", 64'(m_ir), 64'd1);

    // random traffic under various IRs, including pause states
    for (int r = 0; r < 6; r++) begin
      to_rti();
      case (r % 4)
        0: pick = USER_IR;
        1: pick = IDCODE_IR;
        2: pick = 6'h3F;
        default: pick = 6'($urandom);
      endcase
      shift_ir(pick, iseq);
      chkw("rand_ir_seq", 64'(iseq), 64'(6'b100000));
      for (int k = 0; k < 150; k++)
        step($urandom_range(0, 99) < 25, 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Simulation and soft IEEE 1149.1 TAP controller. Drives the BSCANE2-style user-scan interface (CAPTURE, RESET, RUNTEST, SEL, SHIFT, UPDATE, TDI, TCK) that jtag_rom consumes.
- Sits directly upstream of jtag_rom. It decodes the raw TMS/TDI stream, holds the instruction register and the IDCODE/BYPASS registers, and returns the user TDO to the cable.

Parameters:
- IR_LEN, 6: instruction register width.
- USER_IR, 6'h02: opcode that asserts SEL (USER1).
- IDCODE_IR, 6'h09: opcode that selects the IDCODE register.
- IDCODE, 32'h13631093: value captured into the IDCODE register.

Ports:
- TCK  in  1  JTAG clock; the only clock.
- TRST_N  in  1  asynchronous active-low reset.
- TMS  in  1  test mode select, sampled on TCK rising edge.
- TDI  in  1  serial data in, sampled on TCK rising edge.
- TDO  out  1  serial data out, registered on TCK falling edge.
- TDO_EN  out  1  high while TDO is valid (Shift-IR/Shift-DR).
- USER_TDO  in  1  serial return from the downstream user chain.
- CAPTURE  out  1  state == Capture-DR.
- SHIFT  out  1  state == Shift-DR.
- UPDATE  out  1  state == Update-DR.
- RESET  out  1  state == Test-Logic-Reset.
- RUNTEST  out  1  state == Run-Test/Idle.
- SEL  out  1  IR == USER_IR.
- USER_TDI  out  1  pass-through of TDI.

Behaviour:

State machine:
- Standard 16-state TAP: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions occur on TCK rising edge per the 1149.1 TMS table. Examples:
  - TLR: TMS=0 -> RTI.
  - UpdDR/UpdIR: TMS=0 -> RTI, TMS=1 -> SelDR.
  - SelIR: TMS=1 -> TLR.
- Five consecutive TMS=1 edges reach TLR from any state.

Reset (TRST_N low, immediate, asynchronous):
- state=TLR, IR=IDCODE_IR, ir_shift=0, bypass=0, idcode_shift=0, TDO=0.
- Outputs: RESET=1, all others 0. SEL=0 unless USER_IR==IDCODE_IR.
- Entering TLR via TMS has the same effect on IR on the next rising edge (IR=IDCODE_IR). Data shift registers are not cleared.

Status outputs (CAPTURE/SHIFT/UPDATE/RESET/RUNTEST):
- Pure decodes of the registered state. They change just after TCK rising edge, which gives jtag_rom a full half-cycle of setup before its falling-edge sampling.

IR path:
- CapIR: ir_shift <= {IR_LEN-2 zeros, 2'b01}.
- ShIR: ir_shift <= {TDI, ir_shift[IR_LEN-1:1]}.
- UpdIR: IR <= ir_shift on the rising edge that leaves UpdIR.
- SEL updates on that same edge.

DR paths, selected by IR:
- IR==IDCODE_IR: CapDR loads IDCODE; ShDR shifts right with TDI into bit 31.
- IR==USER_IR: data comes from USER_TDO. Block performs no DR capture.
- Any other IR, including all-ones BYPASS: 1-bit bypass; CapDR loads 0, ShDR loads TDI.

TDO (TCK falling edge):
- ShIR: TDO <= ir_shift[0].
- ShDR: TDO <= selected DR LSB (idcode_shift[0], USER_TDO, or bypass).
- Otherwise TDO holds its last value.
- TDO_EN is registered alongside TDO: 1 in ShIR/ShDR, else 0.
- Shift-to-output latency: a bit presented at rising edge N appears on TDO at falling edge N (bypass register, one-TCK delay).

Boundary cases:
- Pause states hold every shift register.
- Ex1->Upd without any shift still updates IR with the captured 000001 pattern.
- TRST_N asserted mid-shift aborts the shift with no UPDATE pulse.
- TRST_N released synchronously to a TCK rising edge: the first transition is taken on the following edge.

Test Plan:
- TRST_N=0 for 3 TCK, then TMS=0 for 1 edge -> RESET=1 during reset, RUNTEST=1 after; IR==6'h09; SEL=0; TDO_EN=0.
- From ShDR with TMS=1 for 5 edges -> state TLR, RESET=1 after the 5th edge; no UPDATE pulse seen on the path Ex1DR->UpdDR counted exactly once.
- IR scan: CapIR then shift 6'b000010 LSB first -> TDO during ShIR shows 1,0,0,0,0,0; after UpdIR, SEL=1. A following DR pass gives CAPTURE=1 for exactly one TCK, then SHIFT=1 for 64 TCK. TDO mirrors USER_TDO with jtag_rom-style data, so the bench readout equals the ROM word.
- IDCODE: after reset, go to ShDR and shift 32 bits with TDI=0 -> TDO LSB-first sequence reconstructs 32'h13631093, followed by zeros.
- BYPASS: load IR=6'h3F, shift TDI pattern 1,0,1,1 -> TDO shows 0,1,0,1,1 (one-bit delay, leading captured 0).
- TRST_N pulsed low during the 10th bit of a USER ShDR -> SHIFT drops immediately; RESET=1; SEL=0; no UPDATE afterwards until a new IR scan.
